// File: rtl/regwr_pkg.sv
// regwr_pkg: shared constants and helpers for the register-bank write arbiter.
//   REGWR_NREQ / REGWR_NREG / REGWR_AW / REGWR_SIZE : default parameter values
//   onehot_idx(idx) : index -> one-hot vector (ONEHOT_W bits, zero if idx too big)
package regwr_pkg;

  localparam int REGWR_NREQ = 4;
  localparam int REGWR_NREG = 8;
  localparam int REGWR_AW   = 3;
  localparam int REGWR_SIZE = 16;

  // Widest one-hot vector the helper produces; callers slice the low bits.
  localparam int ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot_idx(input int unsigned idx);
    // Shifting past the vector width yields all-zero, which callers rely on.
    onehot_idx = ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/regwr_arbiter_if.sv
// regwr_arbiter_if: request/grant bus between write requesters and the arbiter.
//   req       : per-requester write request (level)
//   addr      : packed target addresses, requester i at [i*AW +: AW]
//   wdata     : packed write data, requester i at [i*SIZE +: SIZE]
//   gnt       : one-hot grant (registered)
//   reg_en    : one-hot write enable to the register bank (registered)
//   reg_wdata : write data to the register bank (registered)
//   busy      : an eligible request lost arbitration in the previous cycle
// Handshake: a requester holds req/addr/wdata stable until it sees its gnt
// bit high; the write completes on the edge where gnt is sampled high. A req
// still high in the cycle after gnt falls is a new request.
// Modports: master = requester side, slave = arbiter side.
interface regwr_arbiter_if
  import regwr_pkg::*;
#(
  parameter int NREQ = REGWR_NREQ,
  parameter int NREG = REGWR_NREG,
  parameter int AW   = REGWR_AW,
  parameter int SIZE = REGWR_SIZE
);
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*SIZE-1:0] wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREG-1:0]      reg_en;
  logic [SIZE-1:0]      reg_wdata;
  logic                 busy;

  modport master (output req, addr, wdata, input gnt, reg_en, reg_wdata, busy);
  modport slave  (input req, addr, wdata, output gnt, reg_en, reg_wdata, busy);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   elig_i  : eligible vector
//   last_i  : index of the most recent winner; the search starts at last_i+1
//   valid_o : some bit of elig_i is set
//   idx_o   : first eligible index at or after last_i+1, wrapping modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // k = N revisits last_i itself, so a lone eligible last winner still wins.
    for (int k = 1; k <= N; k++) begin
      if (!valid_o && elig_i[(int'(last_i) + k) % N]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(last_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: round-robin arbiter for the single write port of the
// register bank. Grants at most one request per cycle; a requester granted
// this cycle is masked next cycle. All bus outputs are registered.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : regwr_arbiter_if.slave (req/addr/wdata in, gnt/reg_en/reg_wdata/busy out)
// Build option: REGWR_ZERO_REG_EN -- register 0 is hardwired zero; writes to
// address 0 are still granted but reg_en[0] never asserts.
module regwr_arbiter
  import regwr_pkg::*;
#(
  parameter int NREQ = REGWR_NREQ,
  parameter int NREG = REGWR_NREG,
  parameter int AW   = REGWR_AW,
  parameter int SIZE = REGWR_SIZE
) (
  input logic            clk,
  input logic            rst_n,
  regwr_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREG-1:0]     en_q, en_d;
  logic [SIZE-1:0]     wd_q, wd_d;
  logic                busy_q, busy_d;
  logic [IW-1:0]       last_q, last_d;

  logic [NREQ-1:0]     elig;
  logic                win_valid;
  logic [IW-1:0]       win_idx;
  logic [AW-1:0]       win_addr;
  logic [ONEHOT_W-1:0] gnt_oh;
  logic [ONEHOT_W-1:0] en_oh;

  // A requester holding gnt this cycle has just been served.
  assign elig = bus.req & ~gnt_q;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .elig_i  (elig),
    .last_i  (last_q),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    win_addr = bus.addr[int'(win_idx)*AW +: AW];
    gnt_oh   = onehot_idx(int'(win_idx));
    en_oh    = onehot_idx(int'(win_addr));
    gnt_d    = '0;
    en_d     = '0;
    wd_d     = '0;
    last_d   = last_q;
    busy_d   = $countones(elig) > 1;
    if (win_valid) begin
      gnt_d  = gnt_oh[NREQ-1:0];
      wd_d   = bus.wdata[int'(win_idx)*SIZE +: SIZE];
      last_d = win_idx;
      // Out-of-range addresses are granted but the write is dropped.
      if (int'(win_addr) < NREG) en_d = en_oh[NREG-1:0];
`ifdef REGWR_ZERO_REG_EN
      en_d[0] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      en_q   <= '0;
      wd_q   <= '0;
      busy_q <= 1'b0;
      last_q <= IW'(NREQ - 1);  // requester 0 gets first priority
    end else begin
      gnt_q  <= gnt_d;
      en_q   <= en_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
      last_q <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.reg_en    = en_q;
  assign bus.reg_wdata = wd_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter: directed bench for regwr_arbiter with a register bank
// model capturing reg_wdata wherever reg_en is high. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_regwr_arbiter;
  import regwr_pkg::*;

  localparam int NREQ = REGWR_NREQ;
  localparam int NREG = REGWR_NREG;
  localparam int AW   = REGWR_AW;
  localparam int SIZE = REGWR_SIZE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regwr_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .SIZE(SIZE)) bus ();

  regwr_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- register bank model ----------------
  logic [SIZE-1:0] bank [NREG] = '{default: '0};
  always @(posedge clk)
    for (int i = 0; i < NREG; i++)
      if (bus.reg_en[i]) bank[i] <= bus.reg_wdata;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [SIZE-1:0] d);
    bus.addr[i*AW +: AW]      = a;
    bus.wdata[i*SIZE +: SIZE] = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [NREQ-1:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NREG-1:0] rr_en  [5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h02};
  logic [SIZE-1:0] rr_wd  [5] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA000};
  logic            sm_g1  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset with every requester asserting.
    rst_n     = 1'b0;
    bus.req   = 4'b1111;
    bus.addr  = '0;
    bus.wdata = '0;
    set_req(0, 3'd1, 16'hA000);
    set_req(1, 3'd2, 16'hA001);
    set_req(2, 3'd3, 16'hA002);
    set_req(3, 3'd4, 16'hA003);
    tick(); tick();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_en", 32'(bus.reg_en), 32'h0);
    check("rst_wd", 32'(bus.reg_wdata), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;

    // Round-robin with all four held: 0,1,2,3,0 and busy throughout.
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt", 32'(bus.gnt), 32'(rr_gnt[k]));
      check("rr_en", 32'(bus.reg_en), 32'(rr_en[k]));
      check("rr_wd", 32'(bus.reg_wdata), 32'(rr_wd[k]));
      check("rr_busy", 32'(bus.busy), 32'h1);
    end
    bus.req = 4'b0000;
    tick();
    check("idle_gnt", 32'(bus.gnt), 32'h0);
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("bank1", 32'(bank[1]), 32'hA000);
    check("bank2", 32'(bank[2]), 32'hA001);
    check("bank3", 32'(bank[3]), 32'hA002);
    check("bank4", 32'(bank[4]), 32'hA003);

    // Single write from requester 2 to register 5.
    set_req(2, 3'd5, 16'hBEEF);
    bus.req = 4'b0100;
    tick();
    check("sw_gnt", 32'(bus.gnt), 32'h4);
    check("sw_en", 32'(bus.reg_en), 32'h20);
    check("sw_wd", 32'(bus.reg_wdata), 32'hBEEF);
    check("sw_busy", 32'(bus.busy), 32'h0);
    bus.req = 4'b0000;
    tick();
    check("sw_bank5", 32'(bank[5]), 32'hBEEF);
    check("sw_gnt_off", 32'(bus.gnt), 32'h0);

    // Self-mask: lone requester held gets every other cycle.
    set_req(1, 3'd6, 16'h5A5A);
    bus.req = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("sm_gnt1", 32'(bus.gnt[1]), 32'(sm_g1[k]));
    end
    bus.req = 4'b0000;
    tick();
    check("sm_bank6", 32'(bank[6]), 32'h5A5A);

    // Two requesters to register 7: last winner was 1, so 3 goes first.
    set_req(0, 3'd7, 16'h1111);
    set_req(3, 3'd7, 16'h2222);
    bus.req = 4'b1001;
    tick();
    check("same_gnt_a", 32'(bus.gnt), 32'h8);
    check("same_busy_a", 32'(bus.busy), 32'h1);
    bus.req = 4'b0001;
    tick();
    check("same_gnt_b", 32'(bus.gnt), 32'h1);
    check("same_busy_b", 32'(bus.busy), 32'h0);
    check("same_bank7_a", 32'(bank[7]), 32'h2222);
    bus.req = 4'b0000;
    tick();
    check("same_bank7_b", 32'(bank[7]), 32'h1111);

    // Write to register 0.
    set_req(0, 3'd0, 16'h1234);
    bus.req = 4'b0001;
    tick();
    check("z_gnt", 32'(bus.gnt), 32'h1);
`ifdef REGWR_ZERO_REG_EN
    check("z_en", 32'(bus.reg_en), 32'h0);
`else
    check("z_en", 32'(bus.reg_en), 32'h1);
`endif
    bus.req = 4'b0000;
    tick();
`ifdef REGWR_ZERO_REG_EN
    check("z_bank0", 32'(bank[0]), 32'h0);
`else
    check("z_bank0", 32'(bank[0]), 32'h1234);
`endif

    // Asynchronous reset in the middle of a grant to register 2.
    set_req(1, 3'd2, 16'hDEAD);
    bus.req = 4'b0010;
    tick();
    check("ar_gnt_pre", 32'(bus.gnt), 32'h2);
    check("ar_en_pre", 32'(bus.reg_en), 32'h4);
    rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(bus.gnt), 32'h0);
    check("ar_en", 32'(bus.reg_en), 32'h0);
    check("ar_wd", 32'(bus.reg_wdata), 32'h0);
    bus.req = 4'b0000;
    tick();
    check("ar_bank2", 32'(bank[2]), 32'hA001);
    rst_n = 1'b1;

    // Priority restarts at requester 0 after reset.
    bus.req = 4'b1111;
    tick();
    check("ar_first_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
